// File: rtl/dcm_lock_supervisor.sv
// dcm_lock_supervisor: reset sequencer, lock qualifier and retry/fault tracker for the CLK125->CLK250 DCM.
// Define DCM_SUPERVISOR_STOP_DETECT_EN to also act on the CLKIN-stopped status bit.
module dcm_lock_supervisor #(
  parameter int RESET_CYCLES  = 8,
  parameter int LOCK_TIMEOUT  = 3300,
  parameter int STABLE_CYCLES = 33,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       CLK33,
  input  logic       rst_n_i,
  input  logic [2:0] dcm_status_i,
  input  logic       force_reset_i,
  input  logic       fault_clear_i,
  output logic       dcm_reset_o,
  output logic       clk_ok_o,
  output logic       fault_o,
  output logic [2:0] retry_count_o,
  output logic [7:0] relock_count_o,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {RESET = 3'd0, WAIT_LOCK = 3'd1, STABLE = 3'd2, RUN = 3'd3, FAULT = 3'd4} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [2:0] retry, retry_n, retry_inc;
  logic [7:0] relock, relock_n;
  logic [2:0] sync1, sync2;
  logic locked, ovf, hold, lost, fail;
  assign locked = sync2[2];
  assign ovf = sync2[0];
  assign retry_inc = (retry == 3'd7) ? retry : retry + 3'd1;
`ifdef DCM_SUPERVISOR_STOP_DETECT_EN
  logic stop_q;
  always_ff @(posedge CLK33 or negedge rst_n_i)
    if (!rst_n_i) stop_q <= 1'b0;
    else stop_q <= sync2[1];
  assign hold = sync2[1];
  assign lost = !locked || (sync2[1] && stop_q);
`else
  logic unused_stop;
  assign unused_stop = sync2[1];
  assign hold = 1'b0;
  assign lost = !locked;
`endif
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_WIDTH'(1);
    retry_n  = retry;
    relock_n = relock;
    fail     = 1'b0;
    case (state)
      RESET:
        if (cnt == CNT_WIDTH'(RESET_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      WAIT_LOCK:
        if (locked) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (hold) cnt_n = cnt;
        else fail = cnt == CNT_WIDTH'(LOCK_TIMEOUT - 1);
      STABLE:
        if (!locked || ovf) fail = 1'b1;
        else if (cnt == CNT_WIDTH'(STABLE_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
          retry_n = '0;
        end
      RUN: begin
        cnt_n = '0;
        if (lost) begin
          state_n  = RESET;
          relock_n = relock + 8'd1;
        end
      end
      FAULT: begin
        cnt_n = '0;
        if (fault_clear_i) begin
          state_n = RESET;
          retry_n = '0;
        end
      end
      default: begin
        state_n = RESET;
        cnt_n   = '0;
      end
    endcase
    if (fail) begin
      state_n = (retry_inc == 3'(MAX_RETRIES)) ? FAULT : RESET;
      cnt_n   = '0;
      retry_n = retry_inc;
    end
    // a software relock overrides any status-driven move, including a RUN lock-loss count
    if (force_reset_i && state != FAULT) begin
      state_n  = RESET;
      cnt_n    = '0;
      retry_n  = '0;
      relock_n = relock;
    end
  end
  always_ff @(posedge CLK33 or negedge rst_n_i)
    if (!rst_n_i) begin
      sync1  <= '0;
      sync2  <= '0;
      state  <= RESET;
      cnt    <= '0;
      retry  <= '0;
      relock <= '0;
    end else begin
      sync1  <= dcm_status_i;
      sync2  <= sync1;
      state  <= state_n;
      cnt    <= cnt_n;
      retry  <= retry_n;
      relock <= relock_n;
    end
  assign dcm_reset_o    = state == RESET || state == FAULT;
  assign clk_ok_o       = state == RUN;
  assign fault_o        = state == FAULT;
  assign retry_count_o  = retry;
  assign relock_count_o = relock;
  assign state_o        = state;
endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// tb_dcm_lock_supervisor: directed scenarios plus randomized DCM behaviour, checked every cycle
// against a behavioural model of the supervisor's sequencing rules.
module tb_dcm_lock_supervisor;
  localparam int RC = 8, LT = 3300, SC = 33, MR = 4;
`ifdef DCM_SUPERVISOR_STOP_DETECT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif
  logic CLK33 = 1'b0, rst_n_i = 1'b1;
  logic [2:0] dcm_status_i = '0;
  logic force_reset_i = 1'b0, fault_clear_i = 1'b0;
  logic dcm_reset_o, clk_ok_o, fault_o;
  logic [2:0] retry_count_o, state_o;
  logic [7:0] relock_count_o;
  int errors = 0, checks = 0;
  int rel = 0, lock_delay = 50, burst = 0, n, t_lock;
  bit never = 1'b0;
  int m_st = 0, m_t = 0, m_retry = 0, m_relock = 0;
  logic [2:0] h [3];
  logic [2:0] m_s, m_sp;

  dcm_lock_supervisor dut (
    .CLK33(CLK33), .rst_n_i(rst_n_i), .dcm_status_i(dcm_status_i),
    .force_reset_i(force_reset_i), .fault_clear_i(fault_clear_i),
    .dcm_reset_o(dcm_reset_o), .clk_ok_o(clk_ok_o), .fault_o(fault_o),
    .retry_count_o(retry_count_o), .relock_count_o(relock_count_o), .state_o(state_o)
  );

  always #15 CLK33 = ~CLK33;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_go(input int st);
    m_st = st;
    m_t = 0;
  endtask

  task automatic m_fail();
    m_retry = (m_retry < 7) ? m_retry + 1 : 7;
    m_go(m_retry == MR ? 4 : 0);
  endtask

  // model: phase 0..4 with elapsed cycles; status is seen two edges late
  always @(posedge CLK33 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_st = 0; m_t = 0; m_retry = 0; m_relock = 0;
      h = '{3'b0, 3'b0, 3'b0};
    end else begin
      m_s = h[1];
      m_sp = h[2];
      h[2] = h[1]; h[1] = h[0]; h[0] = dcm_status_i;
      if (m_st == 4) begin
        if (fault_clear_i) begin m_retry = 0; m_go(0); end
      end else if (force_reset_i) begin
        m_retry = 0; m_go(0);
      end else
        case (m_st)
          0: if (m_t + 1 == RC) m_go(1); else m_t++;
          1: if (m_s[2]) m_go(2);
             else if (!(STOP_EN && m_s[1])) begin
               if (m_t + 1 == LT) m_fail(); else m_t++;
             end
          2: if (!m_s[2] || m_s[0]) m_fail();
             else if (m_t + 1 == SC) begin m_retry = 0; m_go(3); end
             else m_t++;
          3: if (!m_s[2] || (STOP_EN && m_s[1] && m_sp[1])) begin
               m_relock = (m_relock + 1) % 256; m_go(0);
             end
          default: m_go(0);
        endcase
    end
  end

  task automatic tick(input logic [2:0] st, input logic fr, input logic fc);
    dcm_status_i = st; force_reset_i = fr; fault_clear_i = fc;
    @(posedge CLK33); #1;
    check("state", state_o, m_st);
    check("dcm_reset", dcm_reset_o, m_st == 0 || m_st == 4);
    check("clk_ok", clk_ok_o, m_st == 3);
    check("fault", fault_o, m_st == 4);
    check("retry", retry_count_o, m_retry);
    check("relock", relock_count_o, m_relock);
  endtask

  task automatic dcm(input int cnt, input logic stp);
    for (int i = 0; i < cnt; i++) begin
      rel = dcm_reset_o ? 0 : rel + 1;
      tick({rel >= lock_delay && !never, stp, 1'b0}, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_state(input logic [2:0] want, input int limit, input string tag);
    int k = 0;
    while (state_o !== want && k < limit) begin dcm(1, 1'b0); k++; end
    check(tag, state_o, want);
  endtask

  initial begin
    #5 rst_n_i = 1'b0;
    #5;
    check("rst_state", state_o, 0);
    check("rst_dcm_reset", dcm_reset_o, 1);
    check("rst_clk_ok", clk_ok_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_retry", retry_count_o, 0);
    check("rst_relock", relock_count_o, 0);
    @(negedge CLK33); rst_n_i = 1'b1;
    n = 0;
    while (dcm_reset_o && n < 100) begin dcm(1, 1'b0); n++; end
    check("reset_len", n, RC);
    t_lock = -1;
    while (!clk_ok_o && n < 1000) begin
      dcm(1, 1'b0); n++;
      if (t_lock < 0 && dcm_status_i[2]) t_lock = n;
    end
    check("lock_to_ok", n - t_lock, SC + 2);
    check("a_state", state_o, 3);
    check("a_retry", retry_count_o, 0);
    tick(3'b100, 1'b1, 1'b0);
    check("force_run_state", state_o, 0);
    check("force_run_relock", relock_count_o, 0);
    check("force_run_clk_ok", clk_ok_o, 0);
    never = 1'b1;
    dcm(MR * (RC + LT) - 1, 1'b0);
    check("b_pre_state", state_o, 1);
    check("b_pre_retry", retry_count_o, MR - 1);
    dcm(1, 1'b0);
    check("b_state", state_o, 4);
    check("b_fault", fault_o, 1);
    check("b_dcm_reset", dcm_reset_o, 1);
    check("b_retry", retry_count_o, MR);
    tick(3'b000, 1'b1, 1'b0);
    check("fault_force", state_o, 4);
    dcm(20, 1'b0);
    check("fault_hold", state_o, 4);
    never = 1'b0;
    tick(3'b000, 1'b0, 1'b1);
    check("clear_state", state_o, 0);
    check("clear_fault", fault_o, 0);
    check("clear_retry", retry_count_o, 0);
    dcm(RC - 1, 1'b0);
    check("clear_rst_len", state_o, 0);
    dcm(1, 1'b0);
    check("clear_wait", state_o, 1);
    wait_state(3, 300, "c_run");
    tick(3'b000, 1'b0, 1'b0);
    n = 1;
    while (clk_ok_o && n < 10) begin dcm(1, 1'b0); n++; end
    check("drop_ok_fall", n, 3);
    check("drop_relock", relock_count_o, 1);
    n = 0;
    while (dcm_reset_o && n < 100) begin dcm(1, 1'b0); n++; end
    check("drop_rst_len", n, RC);
    wait_state(3, 300, "drop_relocked");
    tick(3'b100, 1'b1, 1'b0);
    wait_state(2, 300, "d_stable");
    dcm(19, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
    dcm(2, 1'b0);
    check("glitch_state", state_o, 0);
    check("glitch_retry", retry_count_o, 1);
    wait_state(3, 300, "d_run");
    check("d_retry", retry_count_o, 0);
    dcm(1, 1'b1); dcm(4, 1'b0);
    check("stop1_state", state_o, 3);
    dcm(2, 1'b1); dcm(3, 1'b0);
    check("stop2_state", state_o, STOP_EN ? 0 : 3);
    check("stop2_relock", relock_count_o, STOP_EN ? 2 : 1);
    wait_state(3, 300, "e_run");
    #3 rst_n_i = 1'b0;
    #2;
    check("arst_state", state_o, 0);
    check("arst_clk_ok", clk_ok_o, 0);
    check("arst_relock", relock_count_o, 0);
    check("arst_dcm_reset", dcm_reset_o, 1);
    @(negedge CLK33); rst_n_i = 1'b1; rel = 0;
    wait_state(3, 300, "f_run");
    lock_delay = 0;
    for (int k = 0; k < 256; k++) begin
      tick(3'b000, 1'b0, 1'b0);
      dcm(2, 1'b0);
      wait_state(3, 200, "wrap_run");
    end
    check("wrap_relock", relock_count_o, 0);
    for (int i = 0; i < 30000; i++) begin
      if (dcm_reset_o) begin
        rel = 0;
        lock_delay = ($urandom_range(0, 7) == 0) ? LT + 100 : int'($urandom_range(0, 300));
      end else rel++;
      if ($urandom_range(0, 99) == 0) burst = $urandom_range(1, 6);
      tick({rel >= lock_delay && $urandom_range(0, 199) != 0, burst > 0, $urandom_range(0, 299) == 0},
           $urandom_range(0, 999) == 0, $urandom_range(0, 49) == 0);
      if (burst > 0) burst--;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcm_lock_supervisor.md
Name: dcm_lock_supervisor

Overview:
- Sequences reset of the CLK125->CLK250 multiplier DCM (the u_multip instance in the infrastructure module): drives its dcm_reset_i, watches the 3-bit dcm_status_o, and retries on lock failure.
- Publishes a qualified clk_ok_o that gates downstream CLK250 users.
- Latches a sticky fault when retries are exhausted.
- Runs on CLK33, a clock independent of the supervised DCM, with async active-low reset.

Parameters:
- RESET_CYCLES, 8: CLK33 cycles dcm_reset_o is held high per attempt (DCM needs >=3 CLKIN periods).
- LOCK_TIMEOUT, 3300: CLK33 cycles (~100 us) allowed for LOCKED after reset release.
- STABLE_CYCLES, 33: consecutive locked cycles required before clk_ok_o asserts.
- MAX_RETRIES, 4: failed attempts before FAULT.
- CNT_WIDTH, 16: width of the internal cycle counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- CLK33  input  1  supervisor clock
- rst_n_i  input  1  asynchronous active-low reset
- dcm_status_i  input  3  from dcm_status_o: [0] phase overflow, [1] CLKIN stopped, [2] LOCKED; asynchronous to CLK33
- force_reset_i  input  1  single-cycle software request for a full relock
- fault_clear_i  input  1  single-cycle clear of FAULT
- dcm_reset_o  output  1  to DCM RST (dcm_reset_i of infrastructure)
- clk_ok_o  output  1  CLK250 qualified stable
- fault_o  output  1  sticky: retries exhausted
- retry_count_o  output  3  failed attempts in the current sequence, saturating at 7
- relock_count_o  output  8  lock losses seen in RUN, wraps 255->0
- state_o  output  3  encoded FSM state for status register readback

Behaviour:
- Reset values: dcm_reset_o=1, clk_ok_o=0, fault_o=0, retry_count_o=0, relock_count_o=0, state_o=RESET(0).
- Async reset clears all state immediately. The first cycle after deassertion begins a RESET period with the counter at 0.
- dcm_status_i passes through a 2-FF synchronizer. All decisions use the synced value (2-cycle input latency).
- States and encodings: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- RESET
  - dcm_reset_o=1; counter increments.
  - At counter==RESET_CYCLES-1: go to WAIT_LOCK, clear counter.
- WAIT_LOCK
  - dcm_reset_o=0.
  - LOCKED=1: go to STABLE, clear counter.
  - Else at counter==LOCK_TIMEOUT-1: failed attempt, retry_count++.
    - New count == MAX_RETRIES: go to FAULT.
    - Otherwise: go to RESET.
- STABLE
  - LOCKED=0 or status[0]=1: failed attempt, handled as in WAIT_LOCK.
  - At counter==STABLE_CYCLES-1: go to RUN; clear retry_count.
- RUN
  - clk_ok_o=1, registered; asserts the cycle the state becomes RUN.
  - LOCKED=0: relock_count++, clk_ok_o drops in the same registered cycle, go to RESET. retry_count is not incremented.
- FAULT
  - dcm_reset_o=1 (DCM held in reset), fault_o=1, clk_ok_o=0.
  - Stays until fault_clear_i: then fault_o=0, retry_count=0, go to RESET.
- force_reset_i, in any state except FAULT: go to RESET with counter cleared and retry_count cleared. clk_ok_o drops next cycle. Ignored in FAULT.
- Priority when events coincide: rst_n_i > fault_clear_i > force_reset_i > status-driven transitions.
- A timeout and LOCKED arriving on the same cycle in WAIT_LOCK: LOCKED wins.
- clk_ok_o is never high in any state other than RUN.

Optional Feature:
- Macro: DCM_SUPERVISOR_STOP_DETECT_EN.
- Defined:
  - In RUN, synced status[1] (CLKIN stopped) high for 2 consecutive cycles is treated as lock loss (relock_count++, go to RESET), even while LOCKED still reads 1.
  - In WAIT_LOCK, status[1] high holds the timeout counter at its current value (no timeout while input clock is absent).
- Undefined: status[1] is ignored everywhere; only LOCKED and status[0] (STABLE only) are used.

Test Plan:
- Reset release, LOCKED rises 50 cycles after dcm_reset_o falls:
  - dcm_reset_o high exactly 8 cycles.
  - clk_ok_o rises 33 cycles after synced LOCKED.
  - retry_count_o=0, state_o=3.
- LOCKED never asserts:
  - 4 attempts of 8 reset + 3300 wait cycles each.
  - Then state_o=4, fault_o=1, dcm_reset_o=1, retry_count_o=4.
  - fault_clear_i pulse -> fault_o=0, new RESET period starts.
- In RUN, drop LOCKED for 1 cycle:
  - clk_ok_o falls within 3 cycles of the drop.
  - relock_count_o 0->1, dcm_reset_o pulses 8 cycles, relock completes.
- LOCKED glitches low at cycle 20 of STABLE:
  - retry_count_o=1, back to RESET, clk_ok_o never asserts.
  - Second attempt succeeds -> retry_count_o=0 in RUN.
- force_reset_i in RUN and in FAULT:
  - RUN: immediate RESET, relock_count_o unchanged.
  - FAULT: no effect, state_o stays 4.
- With DCM_SUPERVISOR_STOP_DETECT_EN, status[1]=1 for 2 synced cycles in RUN with LOCKED=1 -> RESET entered, relock_count_o+1. Without the macro -> stays in RUN.
